// File: rtl/key_debouncer.sv
// Press/release debouncer for a scanned key code. It confirms a code after
// DEBOUNCE_CYCLES stable samples and confirms a release the same way.
module key_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig_in,
  input  logic             key_pressed,
  output logic [WIDTH-1:0] sig_out,
  output logic             key_valid,
  output logic             key_held,
  output logic [1:0]       state_dbg
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [WIDTH-1:0] cand;

  assign state_dbg = state;

  // key_valid is a one-cycle strobe with no ready/backpressure: a consumer
  // that needs the code takes sig_out on that cycle (sig_out is held anyway).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= '0;
      cand      <= '0;
      sig_out   <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          counter <= '0;
          if (key_pressed) begin
            cand  <= sig_in;
            state <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!key_pressed) begin
            counter <= '0;
            state   <= IDLE;
          end else if (sig_in != cand) begin
            // A new code restarts the stability measurement.
            cand    <= sig_in;
            counter <= '0;
          end else if (counter == CNT_MAX) begin
            counter   <= '0;
            sig_out   <= cand;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        HELD: begin
          counter <= '0;
          if (!key_pressed) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (key_pressed) begin
            // Release bounce: back to HELD without reporting a new press.
            counter <= '0;
            state   <= HELD;
          end else if (counter == CNT_MAX) begin
            counter  <= '0;
            key_held <= 1'b0;
            state    <= IDLE;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        default: begin
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/key_debouncer.md
# key_debouncer

Parametrised successor to the keypad debouncer. It qualifies a WIDTH-bit key code together with its `key_pressed` strobe from the keypad scanner, and debounces both press and release. It emits a single-cycle `key_valid` pulse per confirmed press and holds the code on `sig_out` for the display/latch logic downstream. The debounce interval is a parameter, so simulation instances use short counts and no `force` is needed.

## Interface
- `WIDTH`, 4: key code width in bits (≥1).
- `DEBOUNCE_CYCLES`, 960000: consecutive stable samples required to confirm a press or a release (≥2). Internal counter width is ceil(log2(DEBOUNCE_CYCLES)).

Ports:
- `clk` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `sig_in` input WIDTH: raw key code from the scanner.
- `key_pressed` input 1: raw "some key down" indication from the scanner.
- `sig_out` output WIDTH: last confirmed key code; retained after release.
- `key_valid` output 1: one-cycle pulse on each confirmed new press.
- `key_held` output 1: high from press confirmation until release confirmation.

## Operation
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Internal registers: `cand[WIDTH-1:0]` and `counter`.
- IDLE: `counter`=0.
  - `key_pressed`=1 → capture `sig_in` into `cand`, go to PRESS_WAIT, `counter`=0.
- PRESS_WAIT:
  - `key_pressed`=0 → IDLE.
  - `key_pressed`=1 and `sig_in`≠`cand` → recapture `cand`=`sig_in`, `counter`=0, stay.
  - Otherwise, if `counter`==DEBOUNCE_CYCLES-1 → HELD, `sig_out`←`cand`, `key_valid`←1. Else `counter`+1.
- HELD:
  - `key_held`=1.
  - `key_pressed`=0 → RELEASE_WAIT, `counter`=0.
  - `sig_in` changes while pressed are ignored; no second press is reported until a release is confirmed.
- RELEASE_WAIT:
  - `key_pressed`=1 → HELD, `counter`=0. This is a release bounce: no `key_valid`, `sig_out` unchanged.
  - Otherwise, if `counter`==DEBOUNCE_CYCLES-1 → IDLE, `key_held`←0. Else `counter`+1.
- `key_valid` is registered and cleared on the cycle after it is set. It never stays high for 2 consecutive cycles.
- `counter` never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around path.
- Reset values: state IDLE, `counter`=0, `cand`=0, `sig_out`=0, `key_valid`=0, `key_held`=0.
- Reset asserted mid-operation: all registers take reset values immediately, with no clock required. Any partial count is discarded.

## Timing
- Let edge 0 be the first rising edge that samples `key_pressed`=1 in IDLE. With stable inputs, HELD is entered at edge DEBOUNCE_CYCLES.
- At that edge, `sig_out`, `key_valid` and `key_held` all update together. `key_valid` falls at edge DEBOUNCE_CYCLES+1.
- Release: let edge r be the first rising edge that samples `key_pressed`=0 in HELD. With `key_pressed` held low, `key_held` falls at edge r+DEBOUNCE_CYCLES.
- Any disqualifying sample (drop or code change) restarts the measurement. Latency is counted from the last restart.
- Inputs are assumed synchronous to `clk`; synchronisation is done upstream in the scanner.
- Reset deassertion: first active edge may sample inputs; a press present at deassertion is counted from that edge.

## Test plan
All scenarios use WIDTH=4 and DEBOUNCE_CYCLES=20 unless stated.
- **Clean press:** `sig_in`=4'b1010, `key_pressed`=1 for 40 cycles, then 0 for 40 cycles →
  - `key_valid` single pulse at edge 20; `sig_out`=4'b1010 and `key_held`=1 from edge 20.
  - `key_held`=0 at 20 edges after release; `sig_out` stays 4'b1010.
- **Bouncing press:** `key_pressed`/`sig_in` alternate 1/4'b0101 and 0/4'b0000 for 4 cycles, then stable 1/4'b0101 →
  - exactly one `key_valid`, 20 edges after the final rising sample; `sig_out`=4'b0101.
- **Code change in PRESS_WAIT:** 4'b1010 for 10 cycles, then 4'b0110 held, `key_pressed`=1 throughout →
  - no valid for 1010; one `key_valid` 20 edges after the change; `sig_out`=4'b0110.
- **Release bounce:** in HELD, `key_pressed`=0 for 5 cycles, then 1 →
  - `key_held` stays 1, no `key_valid`, `sig_out` unchanged.
  - A subsequent 20-cycle release drops `key_held`.
- **Async reset:** pull `reset` low mid-PRESS_WAIT (count 12) and again in HELD →
  - all outputs 0 before the next edge.
  - After release of reset with the key still pressed, `key_valid` comes exactly 20 edges later.
- **Parameter sweep:** WIDTH=8, DEBOUNCE_CYCLES=3, `sig_in`=8'hA5 pressed →
  - `key_valid` at edge 3, `sig_out`=8'hA5; `key_held` falls 3 edges after release.
